// File: rtl/button_event_classifier.sv
// Turns a debounced button level into one-cycle press/release pulses and
// short/long/double gesture pulses. All outputs are registered.
//
// Ports:
//   clk, reset (async, active-low)
//   button_in      debounced level, 1 = pressed
//   press_pulse    one cycle per accepted rising edge
//   release_pulse  one cycle per falling edge
//   short_press    single press, released early, no second press in gap
//   long_press     button held for LONG_CYCLES
//   double_press   second press inside the gap window
//   busy           a gesture is in progress
module button_event_classifier #(
  parameter int LONG_CYCLES   = 50_000_000,
  parameter int DOUBLE_CYCLES = 12_500_000,
  parameter int CNT_W         = 26
) (
  input  logic clk,
  input  logic reset,
  input  logic button_in,
  output logic press_pulse,
  output logic release_pulse,
  output logic short_press,
  output logic long_press,
  output logic double_press,
  output logic busy
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    PRESSED = 3'd1,
    LONG    = 3'd2,
    GAP     = 3'd3,
    SECOND  = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] LONG_LAST =
    CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST =
    CNT_W'(DOUBLE_CYCLES - 1);

  state_t           state;
  state_t           state_n;
  logic [CNT_W-1:0] cnt;
  logic             btn_prev;
  logic             armed;
  logic             rise;
  logic             fall;
  logic             long_hit;
  logic             gap_hit;

  logic press_d;
  logic release_d;
  logic short_d;
  logic long_d;
  logic double_d;

  assign rise     = button_in & ~btn_prev;
  assign fall     = ~button_in & btn_prev;
  assign long_hit = (cnt == LONG_LAST);
  assign gap_hit  = (cnt == GAP_LAST);

  // btn_prev resets high so a button held through reset is never
  // reported; armed swallows the fall that this produces.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      cnt      <= '0;
      btn_prev <= 1'b1;
      armed    <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= (state_n != state) ? '0 : cnt + 1'b1;
      btn_prev <= button_in;
      armed    <= armed | fall;
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (rise) state_n = PRESSED;
      PRESSED: begin
        if (fall)          state_n = GAP;
        else if (long_hit) state_n = LONG;
      end
      LONG:    if (fall) state_n = IDLE;
      GAP: begin
        if (rise)         state_n = SECOND;
        else if (gap_hit) state_n = IDLE;
      end
      SECOND:  if (fall) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    press_d   = rise;
    release_d = fall & armed;
    short_d   = 1'b0;
    long_d    = 1'b0;
    double_d  = 1'b0;
    unique case (1'b1)
      (state == PRESSED): long_d   = ~fall & long_hit;
      (state == GAP):     begin
        double_d = rise;
        short_d  = ~rise & gap_hit;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      short_press   <= 1'b0;
      long_press    <= 1'b0;
      double_press  <= 1'b0;
      busy          <= 1'b0;
    end else begin
      press_pulse   <= press_d;
      release_pulse <= release_d;
      short_press   <= short_d;
      long_press    <= long_d;
      double_press  <= double_d;
      busy          <= (state_n != IDLE);
    end
  end

endmodule

// File: tb/tb_button_event_classifier.sv
// Bench for button_event_classifier: directed gestures plus random
// press/release runs compared against a timestamp-based gesture model.
module tb_button_event_classifier;

  localparam int LC = 8;
  localparam int DC = 5;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic button_in = 1'b0;
  logic press_pulse;
  logic release_pulse;
  logic short_press;
  logic long_press;
  logic double_press;
  logic busy;

  int total = 0;
  int passed = 0;

  button_event_classifier #(
    .LONG_CYCLES(LC),
    .DOUBLE_CYCLES(DC),
    .CNT_W(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .button_in(button_in),
    .press_pulse(press_pulse),
    .release_pulse(release_pulse),
    .short_press(short_press),
    .long_press(long_press),
    .double_press(double_press),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // model: gesture phase plus edge timestamps
  typedef enum int {
    G_NONE, G_HELD, G_HELD_LONG, G_WAIT, G_SECOND
  } gest_t;

  gest_t g;
  int    now;
  int    t_press;
  int    t_rel;
  logic  m_prev;
  logic  m_seen_fall;
  logic  e_press, e_rel, e_short, e_long, e_dbl, e_busy;

  task automatic model_reset();
    g = G_NONE;
    m_prev = 1'b1;
    m_seen_fall = 1'b0;
    {e_press, e_rel, e_short, e_long, e_dbl, e_busy} = '0;
  endtask

  task automatic model_edge(input logic b);
    logic r;
    logic f;
    now++;
    r = b & ~m_prev;
    f = ~b & m_prev;
    e_press = r;
    e_rel   = f & m_seen_fall;
    if (f) m_seen_fall = 1'b1;
    e_short = 1'b0;
    e_long  = 1'b0;
    e_dbl   = 1'b0;
    case (g)
      G_NONE: if (r) begin
        g = G_HELD;
        t_press = now;
      end
      G_HELD:
        if (f) begin
          g = G_WAIT;
          t_rel = now;
        end else if (now - t_press == LC) begin
          e_long = 1'b1;
          g = G_HELD_LONG;
        end
      G_HELD_LONG: if (f) g = G_NONE;
      G_WAIT:
        if (r) begin
          e_dbl = 1'b1;
          g = G_SECOND;
        end else if (now - t_rel == DC) begin
          e_short = 1'b1;
          g = G_NONE;
        end
      G_SECOND: if (f) g = G_NONE;
      default: g = G_NONE;
    endcase
    e_busy = (g != G_NONE);
    m_prev = b;
  endtask

  task automatic check(input string tag, input logic obs,
                       input logic exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s t=%0d observed=%0b expected=%0b",
                tag, now, obs, exp);
  endtask

  task automatic check_all();
    check("press_pulse", press_pulse, e_press);
    check("release_pulse", release_pulse, e_rel);
    check("short_press", short_press, e_short);
    check("long_press", long_press, e_long);
    check("double_press", double_press, e_dbl);
    check("busy", busy, e_busy);
  endtask

  task automatic step(input logic b);
    @(negedge clk);
    button_in = b;
    @(posedge clk);
    model_edge(b);
    #1;
    check_all();
  endtask

  task automatic hold(input logic b, input int n);
    for (int i = 0; i < n; i++) step(b);
  endtask

  task automatic do_reset(input logic b, input int n);
    @(negedge clk);
    reset = 1'b0;
    button_in = b;
    #1;
    model_reset();
    check_all();
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      now++;
      #1;
      check_all();
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  int plen;
  int rlen;

  initial begin
    now = 0;
    t_press = 0;
    t_rel = 0;
    model_reset();

    // reset with button released, then idle
    do_reset(1'b0, 3);
    hold(1'b0, 20);

    // short press
    hold(1'b1, 3);
    hold(1'b0, 10);

    // long press
    hold(1'b1, 12);
    hold(1'b0, 10);

    // double press
    hold(1'b1, 2);
    hold(1'b0, 2);
    hold(1'b1, 2);
    hold(1'b0, 10);

    // second rise exactly on the gap-timeout edge
    hold(1'b1, 2);
    hold(1'b0, DC);
    hold(1'b1, 2);
    hold(1'b0, 10);

    // fall exactly on the long-timeout edge
    hold(1'b1, LC);
    hold(1'b0, 10);

    // button held through reset, then release and re-press
    hold(1'b1, 3);
    do_reset(1'b1, 2);
    hold(1'b1, 4);
    hold(1'b0, 3);
    hold(1'b1, 2);
    hold(1'b0, 10);

    // reset while in LONG
    hold(1'b1, 10);
    do_reset(1'b0, 2);
    hold(1'b0, 4);

    // reset while in GAP
    hold(1'b1, 2);
    hold(1'b0, 2);
    do_reset(1'b0, 2);
    hold(1'b0, 8);

    // random gestures
    for (int k = 0; k < 40; k++) begin
      plen = $urandom_range(1, 12);
      rlen = $urandom_range(1, 8);
      hold(1'b1, plen);
      hold(1'b0, rlen);
    end
    hold(1'b0, 12);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
